// File: rtl/dsi_timing_recovery_pkg.sv
// -----------------------------------------------------------------------------
// dsi_timing_recovery_pkg
// Shared constants for the DSI receive-side timing recovery block:
//   - PTYPE_* DSI data-type codes used on hdr_type_i
//   - REG_RX_* host register addresses
//   - FSM state encodings
//   - helpers for RGB24 word-count decoding
// -----------------------------------------------------------------------------
package dsi_timing_recovery_pkg;

    // DSI data types
    localparam logic [5:0] PTYPE_VSYNC_START = 6'h01;
    localparam logic [5:0] PTYPE_HSYNC_START = 6'h21;
    localparam logic [5:0] PTYPE_BLANKING    = 6'h19;
    localparam logic [5:0] PTYPE_RGB24       = 6'h3E;

    // Host register map
    localparam logic [3:0] REG_RX_PIXELS    = 4'd0;
    localparam logic [3:0] REG_RX_RGB_LINES = 4'd1;
    localparam logic [3:0] REG_RX_LINES     = 4'd2;
    localparam logic [3:0] REG_RX_STATUS    = 4'd3;
    localparam logic [3:0] REG_RX_CTRL      = 4'd8;

    // Receive FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RGB  = 2'd1;
    localparam logic [1:0] ST_SKIP = 2'd2;

    localparam logic [15:0] STRAY_MAX = 16'hFFFF;

    // An RGB24 payload is only usable when it holds a whole number of pixels.
    function automatic logic wc_is_rgb_aligned(input logic [15:0] wc);
        return (wc % 16'd3) == 16'd0;
    endfunction

    // Pixels per line from the byte count, truncated to the 12-bit counter width.
    function automatic logic [11:0] wc_to_pixels(input logic [15:0] wc);
        logic [15:0] q;
        q = wc / 16'd3;
        return q[11:0];
    endfunction

endpackage

// File: rtl/dsi_timing_recovery_rgb888_unpack.sv
// -----------------------------------------------------------------------------
// dsi_timing_recovery_rgb888_unpack
// Assembles a payload byte stream into RGB888 pixels. The first byte of each
// triple is R and lands in [23:16].
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        forces the byte phase back to the first byte of a pixel
//   strobe_i       byte_i carries a payload byte this cycle
//   byte_i         payload byte
//   valid_o        one-cycle pulse: pixel_o holds a new pixel
//   pixel_o        last assembled pixel, held until the next one
// -----------------------------------------------------------------------------
module dsi_timing_recovery_rgb888_unpack (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        strobe_i,
    input  logic [7:0]  byte_i,
    output logic        valid_o,
    output logic [23:0] pixel_o
);

    logic [1:0]  phase_q, phase_d;
    logic [7:0]  b0_q, b0_d;
    logic [7:0]  b1_q, b1_d;
    logic [23:0] pix_q, pix_d;
    logic        valid_q, valid_d;

    always_comb begin
        phase_d = phase_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        pix_d   = pix_q;
        valid_d = 1'b0;
        if (clear_i) begin
            phase_d = 2'd0;
        end else if (strobe_i) begin
            case (phase_q)
                2'd0: begin
                    b0_d    = byte_i;
                    phase_d = 2'd1;
                end
                2'd1: begin
                    b1_d    = byte_i;
                    phase_d = 2'd2;
                end
                default: begin
                    pix_d   = {b0_q, b1_q, byte_i};
                    valid_d = 1'b1;
                    phase_d = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= 2'd0;
            b0_q    <= 8'h00;
            b1_q    <= 8'h00;
            pix_q   <= 24'h000000;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign pixel_o = pix_q;

endmodule

// File: rtl/dsi_timing_recovery.sv
// -----------------------------------------------------------------------------
// dsi_timing_recovery
// Rebuilds raster timing (vsync/hsync pulses, display enable, RGB888 pixels)
// from decoded DSI packets and measures frame geometry for the host.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   hdr_valid_i / hdr_ready_o    header handshake
//   hdr_long_i, hdr_type_i,
//   hdr_wcount_i                 header fields
//   pl_valid_i, pl_data_i        payload byte strobe (no backpressure)
//   pix_valid_o, pix_data_o,
//   pix_de_o, pix_hsync_o,
//   pix_vsync_o                  recovered raster outputs
//   host_a_i, host_d_i,
//   host_wr_i, host_d_o          register port, combinational read
//   dbg_state_o                  current FSM state
//
// Handshake: a header transfers on every cycle where hdr_valid_i and
// hdr_ready_o are both high; upstream must hold the header stable until then.
// Payload bytes have no handshake: each pl_valid_i cycle consumes one byte.
// -----------------------------------------------------------------------------
module dsi_timing_recovery
    import dsi_timing_recovery_pkg::*;
#(
    parameter int g_pixel_width = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     hdr_valid_i,
    output logic                     hdr_ready_o,
    input  logic                     hdr_long_i,
    input  logic [5:0]               hdr_type_i,
    input  logic [15:0]              hdr_wcount_i,
    input  logic                     pl_valid_i,
    input  logic [7:0]               pl_data_i,
    output logic                     pix_valid_o,
    output logic [g_pixel_width-1:0] pix_data_o,
    output logic                     pix_de_o,
    output logic                     pix_hsync_o,
    output logic                     pix_vsync_o,
    input  logic [3:0]               host_a_i,
    input  logic [31:0]              host_d_i,
    output logic [31:0]              host_d_o,
    input  logic                     host_wr_i,
    output logic [1:0]               dbg_state_o
);

    logic [1:0]  state_q, state_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [11:0] rgb_cnt_q, rgb_cnt_d;
    logic [11:0] px_live_q, px_live_d;
    logic [11:0] lines_reg_q, lines_reg_d;
    logic [11:0] rgb_lines_reg_q, rgb_lines_reg_d;
    logic [11:0] pixels_reg_q, pixels_reg_d;
    logic        err_q, err_d;
    logic [15:0] stray_q, stray_d;
    logic        en_q, en_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    // Low only until the first clock after reset so hdr_ready_o is 0 in reset.
    logic        run_q;

    logic        accept;
    logic        unpack_valid;
    logic [23:0] unpack_pixel;
    logic        unused_host_bits;

    assign unused_host_bits = ^host_d_i[31:1];

    assign hdr_ready_o = run_q && (state_q == ST_IDLE);
    assign accept      = hdr_valid_i && hdr_ready_o;

    always_comb begin
        state_d         = state_q;
        bcnt_d          = bcnt_q;
        line_cnt_d      = line_cnt_q;
        rgb_cnt_d       = rgb_cnt_q;
        px_live_d       = px_live_q;
        lines_reg_d     = lines_reg_q;
        rgb_lines_reg_d = rgb_lines_reg_q;
        pixels_reg_d    = pixels_reg_q;
        err_d           = err_q;
        stray_d         = stray_q;
        en_d            = en_q;
        hsync_d         = 1'b0;
        vsync_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!hdr_long_i) begin
                        if (hdr_type_i == PTYPE_VSYNC_START) begin
                            vsync_d = 1'b1;
                            if (en_q) begin
                                lines_reg_d     = line_cnt_q;
                                rgb_lines_reg_d = rgb_cnt_q;
                                pixels_reg_d    = px_live_q;
                                line_cnt_d      = 12'd0;
                                rgb_cnt_d       = 12'd0;
                                px_live_d       = 12'd0;
                            end
                        end else if (hdr_type_i == PTYPE_HSYNC_START) begin
                            hsync_d = 1'b1;
                            if (en_q) begin
                                line_cnt_d = line_cnt_q + 12'd1;
                            end
                        end
                    end else if (hdr_wcount_i != 16'd0) begin
                        // Zero-length long packets carry no payload and stay here.
                        bcnt_d = hdr_wcount_i;
                        if (hdr_type_i == PTYPE_RGB24 && wc_is_rgb_aligned(hdr_wcount_i)) begin
                            state_d = ST_RGB;
                            if (en_q) begin
                                rgb_cnt_d = rgb_cnt_q + 12'd1;
                                px_live_d = wc_to_pixels(hdr_wcount_i);
                            end
                        end else begin
                            if (hdr_type_i == PTYPE_RGB24) begin
                                err_d = 1'b1;
                            end
                            state_d = ST_SKIP;
                        end
                    end
                end
                if (pl_valid_i && en_q && (stray_q != STRAY_MAX)) begin
                    stray_d = stray_q + 16'd1;
                end
            end
            ST_RGB, ST_SKIP: begin
                if (pl_valid_i) begin
                    bcnt_d = bcnt_q - 16'd1;
                    if (bcnt_q == 16'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Host writes take priority over same-cycle status updates.
        if (host_wr_i) begin
            if (host_a_i == REG_RX_STATUS) begin
                err_d   = 1'b0;
                stray_d = 16'd0;
            end else if (host_a_i == REG_RX_CTRL) begin
                en_d = host_d_i[0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            bcnt_q          <= 16'd0;
            line_cnt_q      <= 12'd0;
            rgb_cnt_q       <= 12'd0;
            px_live_q       <= 12'd0;
            lines_reg_q     <= 12'd0;
            rgb_lines_reg_q <= 12'd0;
            pixels_reg_q    <= 12'd0;
            err_q           <= 1'b0;
            stray_q         <= 16'd0;
            en_q            <= 1'b0;
            hsync_q         <= 1'b0;
            vsync_q         <= 1'b0;
            run_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            bcnt_q          <= bcnt_d;
            line_cnt_q      <= line_cnt_d;
            rgb_cnt_q       <= rgb_cnt_d;
            px_live_q       <= px_live_d;
            lines_reg_q     <= lines_reg_d;
            rgb_lines_reg_q <= rgb_lines_reg_d;
            pixels_reg_q    <= pixels_reg_d;
            err_q           <= err_d;
            stray_q         <= stray_d;
            en_q            <= en_d;
            hsync_q         <= hsync_d;
            vsync_q         <= vsync_d;
            run_q           <= 1'b1;
        end
    end

    // Phase is held clear outside ST_RGB so every RGB payload starts on R.
    dsi_timing_recovery_rgb888_unpack u_unpack (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q != ST_RGB),
        .strobe_i (pl_valid_i && (state_q == ST_RGB)),
        .byte_i   (pl_data_i),
        .valid_o  (unpack_valid),
        .pixel_o  (unpack_pixel)
    );

    assign pix_valid_o = en_q && unpack_valid;
    assign pix_data_o  = en_q ? unpack_pixel : '0;
    // The final pixel pulse lands the cycle after the FSM leaves ST_RGB;
    // OR-ing it in keeps DE high through that last pixel.
    assign pix_de_o    = en_q && ((state_q == ST_RGB) || unpack_valid);
    assign pix_hsync_o = en_q && hsync_q;
    assign pix_vsync_o = en_q && vsync_q;
    assign dbg_state_o = state_q;

    always_comb begin
        host_d_o = 32'd0;
        case (host_a_i)
            REG_RX_PIXELS:    host_d_o = {20'd0, pixels_reg_q};
            REG_RX_RGB_LINES: host_d_o = {20'd0, rgb_lines_reg_q};
            REG_RX_LINES:     host_d_o = {20'd0, lines_reg_q};
            REG_RX_STATUS:    host_d_o = {stray_q, 15'd0, err_q};
            REG_RX_CTRL:      host_d_o = {31'd0, en_q};
            default:          host_d_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_dsi_timing_recovery.sv
// -----------------------------------------------------------------------------
// tb_dsi_timing_recovery
// Self-checking bench for dsi_timing_recovery: a packet vector table plus
// hand-written sequences for frame geometry, stray bytes, zero-length packets,
// asynchronous reset mid-packet and the ENABLE gate. Expected pixels go into
// a scoreboard queue as stimulus is driven and are popped when the DUT emits.
// -----------------------------------------------------------------------------
module tb_dsi_timing_recovery;
    import dsi_timing_recovery_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        hdr_valid_i = 1'b0;
    logic        hdr_ready_o;
    logic        hdr_long_i = 1'b0;
    logic [5:0]  hdr_type_i = 6'h00;
    logic [15:0] hdr_wcount_i = 16'h0000;
    logic        pl_valid_i = 1'b0;
    logic [7:0]  pl_data_i = 8'h00;
    logic        pix_valid_o;
    logic [23:0] pix_data_o;
    logic        pix_de_o;
    logic        pix_hsync_o;
    logic        pix_vsync_o;
    logic [3:0]  host_a_i = 4'h0;
    logic [31:0] host_d_i = 32'h0;
    logic [31:0] host_d_o;
    logic        host_wr_i = 1'b0;
    logic [1:0]  dbg_state_o;

    always #5 clk_i = ~clk_i;

    dsi_timing_recovery dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hdr_valid_i  (hdr_valid_i),
        .hdr_ready_o  (hdr_ready_o),
        .hdr_long_i   (hdr_long_i),
        .hdr_type_i   (hdr_type_i),
        .hdr_wcount_i (hdr_wcount_i),
        .pl_valid_i   (pl_valid_i),
        .pl_data_i    (pl_data_i),
        .pix_valid_o  (pix_valid_o),
        .pix_data_o   (pix_data_o),
        .pix_de_o     (pix_de_o),
        .pix_hsync_o  (pix_hsync_o),
        .pix_vsync_o  (pix_vsync_o),
        .host_a_i     (host_a_i),
        .host_d_i     (host_d_i),
        .host_d_o     (host_d_o),
        .host_wr_i    (host_wr_i),
        .dbg_state_o  (dbg_state_o)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    int          pix_seen = 0;
    int          hs_seen = 0;
    int          vs_seen = 0;
    int          de_seen = 0;
    int          act_seen = 0;
    bit          en_model = 1'b0;

    typedef struct {
        logic [5:0]  ptype;
        logic [15:0] wc;
        logic [7:0]  base;
        int          exp_pix;
        logic        exp_err;
        int          exp_de;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (pix_valid_o) begin
                pix_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pix_unexpected: got pixel 0x%06h, expected none", pix_data_o);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if (pix_data_o !== e) begin
                        errors++;
                        $display("FAIL pix_data: got 0x%06h, expected 0x%06h", pix_data_o, e);
                    end
                end
            end
            if (pix_hsync_o) hs_seen++;
            if (pix_vsync_o) vs_seen++;
            if (pix_de_o)    de_seen++;
            if (pix_valid_o || pix_de_o || pix_hsync_o || pix_vsync_o || (|pix_data_o)) act_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        hdr_valid_i = 1'b0;
        pl_valid_i  = 1'b0;
        host_wr_i   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            clear_inputs();
        end
    endtask

    // Presents a header and returns on the falling edge before the accepting edge.
    task automatic send_hdr(input logic lng, input logic [5:0] t, input logic [15:0] wc,
                            output int waited);
        waited = 0;
        @(negedge clk_i);
        clear_inputs();
        hdr_valid_i  = 1'b1;
        hdr_long_i   = lng;
        hdr_type_i   = t;
        hdr_wcount_i = wc;
        while (!hdr_ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (!hdr_ready_o) begin
            checks++;
            errors++;
            $display("FAIL hdr_accept_timeout: ready=0 after %0d cycles, expected 1", waited);
            hdr_valid_i = 1'b0;
        end
    endtask

    task automatic send_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            clear_inputs();
            pl_valid_i = 1'b1;
            pl_data_i  = base + 8'(i);
        end
    endtask

    task automatic send_short(input logic [5:0] t);
        int w;
        send_hdr(1'b0, t, 16'd0, w);
    endtask

    // Long packet with a counting payload; expected pixels are queued here.
    task automatic send_long(input logic [5:0] t, input logic [15:0] wc, input logic [7:0] base);
        int          w;
        logic [7:0]  b;
        if (en_model && t == PTYPE_RGB24 && wc != 16'd0 && (wc % 16'd3) == 16'd0) begin
            b = base;
            for (int i = 0; i < int'(wc) / 3; i++) begin
                exp_q.push_back({b, b + 8'd1, b + 8'd2});
                b = b + 8'd3;
            end
        end
        send_hdr(1'b1, t, wc, w);
        send_bytes(int'(wc), base);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_i);
        clear_inputs();
        host_a_i  = a;
        host_d_i  = d;
        host_wr_i = 1'b1;
    endtask

    task automatic host_check(input string name, input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk_i);
        clear_inputs();
        host_a_i = a;
        #1;
        check(name, host_d_o, exp);
    endtask

    task automatic run_frame();
        send_short(PTYPE_VSYNC_START);
        for (int l = 0; l < 3; l++) begin
            send_short(PTYPE_HSYNC_START);
            send_long(PTYPE_BLANKING, 16'd6, 8'h80);
            send_long(PTYPE_RGB24, 16'd9, 8'h01);
        end
        send_short(PTYPE_VSYNC_START);
        idle(4);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int p0, d0, h0, v0, a0, w1, w2;

        // ptype, wc, first byte, pixels, ERR_WC, DE cycles
        vecs[0] = '{PTYPE_RGB24,    16'd3,  8'h10, 1, 1'b0, 4};
        vecs[1] = '{PTYPE_RGB24,    16'd12, 8'hA0, 4, 1'b0, 13};
        vecs[2] = '{PTYPE_RGB24,    16'd7,  8'h30, 0, 1'b1, 0};
        vecs[3] = '{PTYPE_BLANKING, 16'd6,  8'h40, 0, 1'b0, 0};
        vecs[4] = '{PTYPE_RGB24,    16'd1,  8'h50, 0, 1'b1, 0};
        vecs[5] = '{6'h29,          16'd5,  8'h60, 0, 1'b0, 0};
        vecs[6] = '{PTYPE_RGB24,    16'd6,  8'hFD, 2, 1'b0, 7};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("reset_outputs", {26'd0, hdr_ready_o, pix_valid_o, pix_de_o, pix_hsync_o,
                                pix_vsync_o, |pix_data_o}, 32'd0);
        check("reset_state", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", {31'd0, hdr_ready_o}, 32'd1);
        host_check("reset_status", REG_RX_STATUS, 32'd0);
        host_check("reset_ctrl", REG_RX_CTRL, 32'd0);
        host_check("reset_lines", REG_RX_LINES, 32'd0);

        host_write(REG_RX_CTRL, 32'h1);
        en_model = 1'b1;
        host_check("ctrl_enable", REG_RX_CTRL, 32'd1);
        host_check("unmapped_read", 4'd5, 32'd0);

        // Table-driven packets
        for (int k = 0; k < 7; k++) begin
            host_write(REG_RX_STATUS, 32'h0);
            idle(2);
            p0 = pix_seen;
            d0 = de_seen;
            send_long(vecs[k].ptype, vecs[k].wc, vecs[k].base);
            @(negedge clk_i);
            clear_inputs();
            check($sformatf("v%0d_ready_after_last", k), {31'd0, hdr_ready_o}, 32'd1);
            idle(3);
            check($sformatf("v%0d_pix_count", k), 32'(pix_seen - p0), 32'(vecs[k].exp_pix));
            check($sformatf("v%0d_de_cycles", k), 32'(de_seen - d0), 32'(vecs[k].exp_de));
            check($sformatf("v%0d_queue_drained", k), 32'(exp_q.size()), 32'd0);
            host_check($sformatf("v%0d_status", k), REG_RX_STATUS, {31'd0, vecs[k].exp_err});
        end

        // Full frame: geometry measurement and sync pulses
        h0 = hs_seen;
        v0 = vs_seen;
        p0 = pix_seen;
        run_frame();
        check("frame_hsync_pulses", 32'(hs_seen - h0), 32'd3);
        check("frame_vsync_pulses", 32'(vs_seen - v0), 32'd2);
        check("frame_pixels_out", 32'(pix_seen - p0), 32'd9);
        check("frame_queue_drained", 32'(exp_q.size()), 32'd0);
        host_check("frame_lines", REG_RX_LINES, 32'd3);
        host_check("frame_rgb_lines", REG_RX_RGB_LINES, 32'd3);
        host_check("frame_pixels", REG_RX_PIXELS, 32'd3);

        // Stray bytes in ST_IDLE
        host_write(REG_RX_STATUS, 32'h0);
        send_bytes(5, 8'hC0);
        idle(2);
        host_check("stray_five", REG_RX_STATUS, 32'h0005_0000);
        host_write(REG_RX_STATUS, 32'h0);
        host_check("status_cleared", REG_RX_STATUS, 32'd0);

        // Zero-length long packet followed immediately by HSYNC_START
        idle(2);
        h0 = hs_seen;
        send_hdr(1'b1, PTYPE_BLANKING, 16'd0, w1);
        send_hdr(1'b0, PTYPE_HSYNC_START, 16'd0, w2);
        idle(3);
        check("wc0_hdr_wait", 32'(w1), 32'd0);
        check("wc0_hsync_hdr_wait", 32'(w2), 32'd0);
        check("wc0_hsync_once", 32'(hs_seen - h0), 32'd1);

        // Asynchronous reset after byte 2 of an RGB24 wc=6 packet
        p0 = pix_seen;
        begin
            int w;
            send_hdr(1'b1, PTYPE_RGB24, 16'd6, w);
        end
        send_bytes(2, 8'h01);
        @(posedge clk_i);
        #2;
        clear_inputs();
        check("pre_reset_state", {30'd0, dbg_state_o}, {30'd0, ST_RGB});
        rst_i = 1'b1;
        #1;
        check("async_reset_state", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
        check("async_reset_ready", {31'd0, hdr_ready_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        en_model = 1'b0;
        host_write(REG_RX_CTRL, 32'h1);
        en_model = 1'b1;
        send_bytes(4, 8'h03);
        idle(3);
        check("reset_no_pixel", 32'(pix_seen - p0), 32'd0);
        host_check("reset_stray_four", REG_RX_STATUS, 32'h0004_0000);

        // ENABLE = 0: full frame produces no pixel-side activity
        host_write(REG_RX_CTRL, 32'h0);
        en_model = 1'b0;
        idle(2);
        a0 = act_seen;
        run_frame();
        check("disabled_no_activity", 32'(act_seen - a0), 32'd0);
        host_check("disabled_lines", REG_RX_LINES, 32'd0);
        host_check("disabled_rgb_lines", REG_RX_RGB_LINES, 32'd0);
        check("disabled_ready", {31'd0, hdr_ready_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/dsi_timing_recovery.md
# dsi_timing_recovery

Receive-side counterpart of the DSI timing generator. It consumes decoded DSI packets (header plus payload byte stream) and rebuilds the raster timing: vsync/hsync pulses, display-enable and RGB888 pixels. It also measures frame geometry into host-readable registers. It sits behind the packet decoder in the loopback/verification path and in any future DSI-input design.

## Interface
- `g_pixel_width`, 24 — output pixel width; only 24 (RGB888) is supported.
- `clk_i` in 1 — single clock domain.
- `rst_i` in 1 — reset, asynchronous assert, active-high.
- `hdr_valid_i` in 1 — packet header valid.
- `hdr_ready_o` out 1 — header accepted when `hdr_valid_i && hdr_ready_o`.
- `hdr_long_i` in 1 — 1 = long packet; a payload of `hdr_wcount_i` bytes follows.
- `hdr_type_i` in 6 — data type, uses the `PTYPE_*` codes.
- `hdr_wcount_i` in 16 — long-packet byte count; ignored for short packets.
- `pl_valid_i` in 1 — payload byte strobe; no backpressure, every strobe is consumed.
- `pl_data_i` in 8 — payload byte.
- `pix_valid_o` out 1 — `pix_data_o` holds a new pixel this cycle.
- `pix_data_o` out 24 — `{R,G,B}`: R = first byte, in [23:16].
- `pix_de_o` out 1 — high while an RGB24 payload is being received.
- `pix_hsync_o` out 1 — one-cycle pulse per HSYNC_START.
- `pix_vsync_o` out 1 — one-cycle pulse per VSYNC_START.
- `host_a_i` in 4 — register address.
- `host_d_i` in 32 — write data.
- `host_d_o` out 32 — read data; combinational mux on `host_a_i`.
- `host_wr_i` in 1 — register write strobe.

## Operation
**States**
- ST_IDLE: `hdr_ready_o` = 1. All other states hold `hdr_ready_o` = 0.
- ST_RGB: receiving an RGB24 payload.
- ST_SKIP: discarding a long payload.

**ST_IDLE, on header accept**
- Short VSYNC_START:
  - pulse `pix_vsync_o`;
  - copy the live counters into the LINES, RGB_LINES and PIXELS registers;
  - clear the live counters.
- Short HSYNC_START: pulse `pix_hsync_o`; line counter +1.
- Other short packets: ignored.
- Long RGB24 with wcount % 3 == 0 and wcount ≠ 0:
  - go to ST_RGB; load byte counter = wcount;
  - RGB line counter +1; live pixel count = wcount/3.
- Long RGB24 with wcount % 3 ≠ 0: set sticky ERR_WC; go to ST_SKIP.
- Any other long packet (including BLANKING) with wcount ≠ 0: go to ST_SKIP.
- Long packet with wcount = 0: stay in ST_IDLE; no payload is expected.

**Payload handling**
- ST_RGB, each `pl_valid_i`:
  - shift the byte into a 3-byte assembler;
  - on the 3rd byte, register the pixel and pulse `pix_valid_o`;
  - byte counter −1.
- ST_SKIP, each `pl_valid_i`: byte counter −1.
- Byte counter reaching 0 returns to ST_IDLE. In ST_RGB the last pixel is still emitted.
- `pl_valid_i` in ST_IDLE is a stray byte:
  - the byte is dropped;
  - STRAY count +1, saturating at 0xFFFF.
- `hdr_valid_i` while a payload is in progress is not accepted. Upstream holds it.

**Enable**
- ENABLE = 0:
  - headers are still accepted and payloads consumed;
  - all `pix_*` outputs are forced to 0;
  - counters do not update.
- Clearing ENABLE mid-packet does not abort the byte count.

**Registers**
- 0 PIXELS (r): pixels/line of the last RGB packet in the previous frame.
- 1 RGB_LINES (r).
- 2 LINES (r): HSYNC count in the previous frame.
- 3 STATUS (r/w):
  - [0] ERR_WC;
  - [31:16] STRAY;
  - any write clears both.
- 8 CTRL (r/w): [0] ENABLE.
- Unmapped addresses read 0.

**Widths**
- Line counters are 12 bits and wrap.
- The byte counter is 16 bits.
- wcount/3 is computed with a constant divider (or by counting) and truncated to 12 bits.

## Timing
- Reset: every output is 0, state = ST_IDLE, all registers are 0.
  - `hdr_ready_o` goes to 1 on the first cycle after reset is released.
- Header-accept edge → `pix_hsync_o`/`pix_vsync_o` high on the following cycle, for exactly 1 cycle.
- 3rd byte strobe at cycle N → `pix_valid_o` at N+1.
  - `pix_data_o` holds its value until the next pixel.
- `pix_de_o` rises the cycle after the RGB header is accepted.
  - It falls the cycle after the final `pix_valid_o`.
- Final byte at cycle N → `hdr_ready_o` = 1 at N+1. Back-to-back headers are then accepted every cycle.
- Host write at cycle N is visible on `host_d_o` at N+1.
- Asynchronous reset mid-packet:
  - immediate return to ST_IDLE;
  - the partial pixel is discarded;
  - remaining payload bytes count as STRAY.

## Structure
- `PTYPE_*` codes and register addresses live in the shared `dsi_defs.vh` include.
  - Add `REG_RX_*` defines there; no new codes inline.
- One sub-module is natural: `dsi_rgb888_unpack`.
  - Byte strobe in → 24-bit pixel plus valid out.
  - Has a clear input that resets the byte phase.

## Test plan
- Reset, then ENABLE = 1:
  - VSYNC_START, then 3× (HSYNC_START, BLANKING wc=6, RGB24 wc=9 bytes 01..09), then VSYNC_START.
  - Expect pixels 010203, 040506, 070809 per line.
  - Expect LINES = 3, RGB_LINES = 3, PIXELS = 3.
- RGB24 wc=7:
  - ERR_WC = 1; no `pix_valid_o`; 7 bytes consumed.
  - The next header is accepted the cycle after byte 7.
- 5 stray bytes in ST_IDLE: STRAY = 5; write reg 3, then STATUS reads 0.
- Long packet wc=0 followed immediately by HSYNC_START:
  - both headers are accepted on consecutive cycles;
  - `pix_hsync_o` pulses once.
- Async reset after byte 2 of an RGB24 wc=6 packet:
  - no pixel is emitted;
  - the remaining 4 bytes are counted as STRAY = 4 (ENABLE re-set after reset).
- ENABLE = 0 with a full frame applied: all `pix_*` outputs stay 0 and LINES stays 0.
